// File: rtl/mem_access_stage.sv
// MEM stage: issues one word load/store per instruction on a req/ack bus with wait states,
// stalls upstream while the access is outstanding, and registers the MEM/WB boundary.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iValid,
  input  logic [31:0] iResult,
  input  logic [31:0] iDatabusB,
  input  logic [31:0] iControlSignal,
  input  logic [4:0]  iRegAddress,
  input  logic [31:0] iPC_plus_4,
  input  logic [31:0] iMemRdata,
  input  logic        iMemAck,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWdata,
  output logic        oStall,
  output logic [31:0] oWBData,
  output logic [4:0]  oRegAddress,
  output logic        oRegWrite,
  output logic        oBusError
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    reg_addr_q, reg_addr_d;
  logic          reg_write_q, reg_write_d;
  logic          bus_error_q, bus_error_d;
  logic [4:0]    pend_rd_q, pend_rd_d;
  logic          pend_load_q, pend_load_d;
  logic          stall;

  logic        mem_write, mem_read, access, misaligned;
  logic [1:0]  mem_to_reg;
  logic [31:0] sel_value;

  assign mem_write  = iControlSignal[0];
  assign mem_read   = iControlSignal[1];
  assign mem_to_reg = iControlSignal[10:9];
  assign access     = iValid & (mem_read | mem_write);
  assign misaligned = access & (iResult[1:0] != 2'b00);
  assign sel_value  = (mem_to_reg == 2'b10) ? iPC_plus_4 : iResult;

  logic unused_ctrl;
  assign unused_ctrl = ^{iControlSignal[31:11], iControlSignal[8:2]};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_rd_d   = pend_rd_q;
    pend_load_d = pend_load_q;
    wb_data_d   = wb_data_q;
    reg_addr_d  = 5'd0;
    bus_error_d = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!access) begin
          wb_data_d  = sel_value;
          reg_addr_d = iValid ? iRegAddress : 5'd0;
        end else if (misaligned) begin
          bus_error_d = 1'b1;
        end else begin
          // Everything needed later is captured here; the slot is not re-read in WAIT.
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write;
          mem_addr_d  = {iResult[31:2], 2'b00};
          mem_wdata_d = iDatabusB;
          pend_rd_d   = iRegAddress;
          pend_load_d = ~mem_write;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iMemAck) begin
          mem_req_d = 1'b0;
          if (pend_load_q) begin
            wb_data_d  = iMemRdata;
            reg_addr_d = pend_rd_q;
          end
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT ack-less cycles have already stalled; this last chance releases the pipe.
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    reg_write_d = (reg_addr_d != 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_write_q <= 1'b0;
      bus_error_q <= 1'b0;
      pend_rd_q   <= '0;
      pend_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_data_q   <= wb_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_write_q <= reg_write_d;
      bus_error_q <= bus_error_d;
      pend_rd_q   <= pend_rd_d;
      pend_load_q <= pend_load_d;
    end
  end

  assign oMemReq     = mem_req_q;
  assign oMemWe      = mem_we_q;
  assign oMemAddr    = mem_addr_q;
  assign oMemWdata   = mem_wdata_q;
  assign oStall      = stall;
  assign oWBData     = wb_data_q;
  assign oRegAddress = reg_addr_q;
  assign oRegWrite   = reg_write_q;
  assign oBusError   = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random instructions, each checked against
// an instruction-level model (stall count, bus request, MEM/WB contents, bus error).
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        iValid;
  logic [31:0] iResult, iDatabusB, iControlSignal, iPC_plus_4, iMemRdata;
  logic [4:0]  iRegAddress;
  logic        iMemAck;
  logic        oMemReq, oMemWe, oStall, oRegWrite, oBusError;
  logic [31:0] oMemAddr, oMemWdata, oWBData;
  logic [4:0]  oRegAddress;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iResult(iResult), .iDatabusB(iDatabusB),
    .iControlSignal(iControlSignal), .iRegAddress(iRegAddress), .iPC_plus_4(iPC_plus_4),
    .iMemRdata(iMemRdata), .iMemAck(iMemAck), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .oStall(oStall), .oWBData(oWBData),
    .oRegAddress(oRegAddress), .oRegWrite(oRegWrite), .oBusError(oBusError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one EX/MEM slot (called at posedge+1), plays the memory with an ack after
  // `delay` ack-less wait cycles, and checks the outcome once the slot is consumed.
  task automatic run_instr(input string tag, input logic valid, input logic [31:0] ctrl,
                           input logic [31:0] result, input logic [31:0] datab,
                           input logic [4:0] rd, input logic [31:0] pc4,
                           input logic [31:0] rdata, input int delay);
    int   stalls = 0;
    int   waits = 0;
    int   cycles = 0;
    logic done = 1'b0;
    logic req_seen = 1'b0;
    logic is_access, mis, is_store, chk_wb, exp_be;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wb;
    int   exp_stalls;

    is_access = valid & (ctrl[0] | ctrl[1]);
    mis       = is_access & (result[1:0] != 2'b00);
    is_store  = ctrl[0];

    iValid = valid; iControlSignal = ctrl; iResult = result; iDatabusB = datab;
    iRegAddress = rd; iPC_plus_4 = pc4; iMemRdata = rdata; iMemAck = 1'b0;

    while (!done) begin
      @(negedge clk);
      if (oMemReq) begin
        if (!req_seen) begin
          check({tag, "_addr"}, oMemAddr, {result[31:2], 2'b00});
          check({tag, "_we"}, {31'd0, oMemWe}, {31'd0, is_store});
          if (is_store) check({tag, "_wdata"}, oMemWdata, datab);
          req_seen = 1'b1;
        end
        iMemAck = (waits == delay);
        waits++;
      end else begin
        iMemAck = 1'b0;
      end
      #1;
      if (oStall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      iMemAck = 1'b0;
      cycles++;
      if (!done && cycles > 3 * TIMEOUT) begin
        total++; bad++;
        $error("FAIL %s_budget: observed=%0d cycles expected=<=%0d", tag, cycles, 3 * TIMEOUT);
        done = 1'b1;
      end
    end

    chk_wb = 1'b0; exp_wb = '0; exp_be = 1'b0; exp_rd = 5'd0; exp_stalls = 0;
    if (!is_access) begin
      chk_wb = 1'b1;
      exp_wb = (ctrl[10:9] == 2'b10) ? pc4 : result;
      exp_rd = valid ? rd : 5'd0;
    end else if (mis) begin
      exp_be = 1'b1;
    end else if (delay > TIMEOUT) begin
      exp_stalls = TIMEOUT + 1;
      exp_be     = 1'b1;
    end else begin
      exp_stalls = 1 + delay;
      if (!is_store) begin
        chk_wb = 1'b1;
        exp_wb = rdata;
        exp_rd = rd;
      end
    end

    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_req_seen"}, {31'd0, req_seen}, {31'd0, is_access & ~mis});
    check({tag, "_req_done"}, {31'd0, oMemReq}, 32'd0);
    check({tag, "_rd"}, {27'd0, oRegAddress}, {27'd0, exp_rd});
    check({tag, "_regwrite"}, {31'd0, oRegWrite}, {31'd0, exp_rd != 5'd0});
    check({tag, "_buserr"}, {31'd0, oBusError}, {31'd0, exp_be});
    if (chk_wb) check({tag, "_wb"}, oWBData, exp_wb);
  endtask

  initial begin
    reset = 1'b0;
    iValid = 1'b0; iResult = '0; iDatabusB = '0; iControlSignal = '0;
    iRegAddress = '0; iPC_plus_4 = '0; iMemRdata = '0; iMemAck = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_req", {31'd0, oMemReq}, 32'd0);
    check("rst_wb", oWBData, 32'd0);
    check("rst_addr", oMemAddr, 32'd0);
    check("rst_bus", {oStall, oRegWrite, oBusError, oMemWe, oRegAddress}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rel_rd", {27'd0, oRegAddress}, 32'd0);
    check("rel_wb", oWBData, 32'd0);

    // Reset while a load is outstanding.
    iValid = 1'b1; iControlSignal = 32'h0000_0202; iResult = 32'h0000_0040; iRegAddress = 5'd3;
    @(posedge clk); #1;
    check("midrst_req_up", {31'd0, oMemReq}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midrst_req_drop", {31'd0, oMemReq}, 32'd0);
    iValid = 1'b0;
    #1;
    check("midrst_idle", {31'd0, oStall}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_instr("alu",      1'b1, 32'h0000_0000, 32'h0000_1234, 32'h0, 5'd5,  32'h44, 32'h0, 0);
    run_instr("load3",    1'b1, 32'h0000_0202, 32'h0000_0100, 32'h0, 5'd8,  32'h48, 32'hDEADBEEF, 3);
    run_instr("store",    1'b1, 32'h0000_0001, 32'h0000_0204, 32'hA5A5A5A5, 5'd9, 32'h4C, 32'h0, 0);
    run_instr("link",     1'b1, 32'h0000_0400, 32'h0000_0777, 32'h0, 5'd31, 32'h50, 32'h0, 0);
    run_instr("timeout",  1'b1, 32'h0000_0202, 32'h0000_0300, 32'h0, 5'd7,  32'h54, 32'h1111, 99);
    run_instr("ack_last", 1'b1, 32'h0000_0202, 32'h0000_0304, 32'h0, 5'd7,  32'h58, 32'h2222, TIMEOUT);
    run_instr("misalign", 1'b1, 32'h0000_0202, 32'h0000_0102, 32'h0, 5'd4,  32'h5C, 32'h0, 0);
    run_instr("after_mis",1'b1, 32'h0000_0000, 32'h0000_0055, 32'h0, 5'd6,  32'h60, 32'h0, 0);
    run_instr("invalid",  1'b0, 32'h0000_0202, 32'h0000_0100, 32'h0, 5'd6,  32'h64, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      int          kind, delay;
      logic [31:0] ctrl, res;
      logic        valid;
      kind  = $urandom_range(0, 5);
      valid = 1'b1;
      res   = $urandom & 32'hFFFF_FFFC;
      ctrl  = $urandom & 32'hFFFF_F9FC;
      delay = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                          : $urandom_range(0, 4);
      case (kind)
        0: ctrl = ctrl | ($urandom_range(0, 1) ? 32'h400 : 32'h0);
        1: ctrl = ctrl | 32'h202;
        2: ctrl = ctrl | 32'h001;
        3: begin
          ctrl = ctrl | (($urandom_range(0, 1) != 0) ? 32'h202 : 32'h001);
          res  = res | 32'($urandom_range(1, 3));
        end
        4: begin
          valid = 1'b0;
          ctrl  = ctrl | 32'($urandom_range(0, 3));
        end
        default: ctrl = ctrl | 32'h200 | 32'($urandom_range(0, 1) << 1);
      endcase
      run_instr($sformatf("rnd%0d", i), valid, ctrl, res, $urandom, 5'($urandom),
                $urandom, $urandom, delay);
    end

    iValid = 1'b0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
